// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit: shift-add multiply and restoring divide, one-cycle RDY pulse.
// Optional MULTDIV_BOOTH4_EN: radix-4 Booth multiply (16 iterations) with identical results.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAST = WIDTH / 2 - 1;
  localparam int MB       = WIDTH + 1;
`else
  localparam int MUL_LAST = WIDTH - 1;
  localparam int MB       = WIDTH;
`endif
  localparam int DIV_LAST = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand, mcand_step, acc, acc_step, product;
  logic [MB-1:0]      mplier, mplier_step;
  logic [WIDTH-1:0]   rem, rem_step, quo, quo_step, quotient, divisor;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg, div_zero, div_ovf, mul_ovf, rem_ge, last;
  logic               start_mul, start_div;

  // Both ctrl lines high together is not a request.
  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    acc_step    = acc;
    mcand_step  = mcand;
    mplier_step = mplier;
`ifdef MULTDIV_BOOTH4_EN
    // Signed Booth digits on the raw operands; no final sign fix needed.
    case (mplier[2:0])
      3'b001, 3'b010: acc_step = acc + mcand;
      3'b011:         acc_step = acc + (mcand << 1);
      3'b100:         acc_step = acc - (mcand << 1);
      3'b101, 3'b110: acc_step = acc - mcand;
      default:        acc_step = acc;
    endcase
    mcand_step  = mcand << 2;
    mplier_step = {{2{mplier[MB-1]}}, mplier[MB-1:2]};
    product     = acc_step;
`else
    if (mplier[0]) acc_step = acc + mcand;
    mcand_step  = mcand << 1;
    mplier_step = mplier >> 1;
    product     = neg ? -acc_step : acc_step;
`endif
    mul_ovf = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));

    rem_shift = {rem, quo[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, divisor};
    rem_step  = rem_ge ? rem_shift[WIDTH-1:0] - divisor : rem_shift[WIDTH-1:0];
    quo_step  = {quo[WIDTH-2:0], rem_ge};
    quotient  = neg ? -quo_step : quo_step;
  end

  always_comb begin
    state_next = state;
    last       = (state == MUL) ? (count == CW'(MUL_LAST)) : (count == CW'(DIV_LAST));
    case (state)
      MUL, DIV: if (last) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // A valid start overrides whatever the current operation was doing.
    if (start_mul)      state_next = MUL;
    else if (start_div) state_next = DIV;
  end

  assign busy           = (state == MUL) || (state == DIV);
  assign data_resultRDY = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_next;
      if (start_mul || start_div) begin
        count    <= '0;
        acc      <= '0;
        rem      <= '0;
        quo      <= mag_a;
        divisor  <= mag_b;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
`ifdef MULTDIV_BOOTH4_EN
        mcand    <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        mplier   <= {data_operandB, 1'b0};
`else
        mcand    <= {{WIDTH{1'b0}}, mag_a};
        mplier   <= mag_b;
`endif
      end else if (busy) begin
        if (count != CW'(WIDTH)) count <= count + CW'(1);
        if (state == MUL) begin
          acc    <= acc_step;
          mcand  <= mcand_step;
          mplier <= mplier_step;
          if (last) begin
            data_result    <= product[WIDTH-1:0];
            data_exception <= mul_ovf;
          end
        end else begin
          rem <= rem_step;
          quo <= quo_step;
          if (last) begin
            data_result    <= div_zero ? '0 : quotient;
            data_exception <= div_zero | div_ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: latency, busy window, results, abort, reset.
// Honours MULTDIV_BOOTH4_EN for the expected multiply latency.
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int failures = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Drives a start so that the following rising edge is E0; operands are scrambled right after.
  task automatic issue(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hA5A5_5A5A;
    data_operandB = 32'h0000_0003;
  endtask

  // Watches edges E1..E(lat+4); samples each at the preceding falling edge.
  task automatic run_op(input string name, input logic is_mul, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    int lat, rdy_edge, rdy_cnt, busy_bad;
    lat = is_mul ? MUL_LAT : DIV_LAT;
    rdy_edge = -1; rdy_cnt = 0; busy_bad = 0;
    issue(is_mul, a, b);
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (rdy_edge < 0) rdy_edge = k;
      end
      if (busy !== (k < lat)) busy_bad++;
      @(posedge clock);
    end
    checks++;
    if (rdy_edge != lat) begin
      failures++; $display("FAIL %s rdy_edge got=%0d exp=%0d", name, rdy_edge, lat);
    end
    checks++;
    if (rdy_cnt != 1) begin
      failures++; $display("FAIL %s rdy_pulses got=%0d exp=1", name, rdy_cnt);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++; $display("FAIL %s busy_window bad_cycles=%0d exp=0", name, busy_bad);
    end
    checks++;
    if (data_result !== exp_res) begin
      failures++; $display("FAIL %s result got=%h exp=%h", name, data_result, exp_res);
    end
    checks++;
    if (data_exception !== exp_exc) begin
      failures++; $display("FAIL %s exception got=%b exp=%b", name, data_exception, exp_exc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got=%h/%b/%b/%b exp=0/0/0/0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul_7x-6", 1'b1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_min_x1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("div_-100/-7", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
    run_op("div_by_zero", 1'b0, 32'd100, 32'd0, 32'd0, 1'b1);
    run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
  endtask

  // DIV 100/7 started at E0, MULT 3x4 at E10: only the multiply completes.
  task automatic test_abort();
    logic [31:0] prev;
    int rdy_cnt, rdy_edge;
    prev = data_result;
    rdy_cnt = 0; rdy_edge = -1;
    issue(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
      @(posedge clock);
    end
    @(negedge clock);
    if (data_resultRDY === 1'b1) rdy_cnt++;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    data_operandA = 32'h1234_5678;
    for (int k = 11; k <= 10 + MUL_LAT + 6; k++) begin
      @(negedge clock);
      if (k == 10 + MUL_LAT - 1) begin
        checks++;
        if (data_result !== prev) begin
          failures++; $display("FAIL abort_hold result got=%h exp=%h", data_result, prev);
        end
      end
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (rdy_edge < 0) rdy_edge = k;
      end
      @(posedge clock);
    end
    checks++;
    if (rdy_cnt != 1) begin
      failures++; $display("FAIL abort_pulses got=%0d exp=1", rdy_cnt);
    end
    checks++;
    if (rdy_edge != 10 + MUL_LAT) begin
      failures++; $display("FAIL abort_rdy_edge got=%0d exp=%0d", rdy_edge, 10 + MUL_LAT);
    end
    checks++;
    if (data_result !== 32'd12 || data_exception !== 1'b0) begin
      failures++; $display("FAIL abort_result got=%h/%b exp=0000000c/0", data_result, data_exception);
    end
  endtask

  task automatic test_both_ctrl();
    int rdy_cnt, rdy_edge, busy_bad;
    // In IDLE: both high must not start anything.
    busy_bad = 0; rdy_cnt = 0;
    @(negedge clock);
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (busy !== 1'b0) busy_bad++;
      if (data_resultRDY !== 1'b0) rdy_cnt++;
    end
    checks++;
    if (busy_bad != 0 || rdy_cnt != 0) begin
      failures++; $display("FAIL both_idle busy_cycles=%0d rdy=%0d exp=0/0", busy_bad, rdy_cnt);
    end
    // Mid-operation at E5: ignored, MULT 5 x -3 completes on time.
    rdy_cnt = 0; rdy_edge = -1;
    issue(1'b1, 32'd5, 32'hFFFF_FFFD);
    for (int k = 1; k <= MUL_LAT + 3; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (rdy_edge < 0) rdy_edge = k;
      end
      if (k == 5) begin ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; end
      else        begin ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; end
      @(posedge clock);
    end
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    checks++;
    if (rdy_cnt != 1 || rdy_edge != MUL_LAT) begin
      failures++; $display("FAIL both_midop rdy_edge=%0d pulses=%0d exp=%0d/1", rdy_edge, rdy_cnt, MUL_LAT);
    end
    checks++;
    if (data_result !== 32'hFFFF_FFF1) begin
      failures++; $display("FAIL both_midop result got=%h exp=fffffff1", data_result);
    end
  endtask

  task automatic test_async_reset();
    int rdy_cnt, busy_bad;
    rdy_cnt = 0; busy_bad = 0;
    issue(1'b1, 32'd9, 32'd9);
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b/%b exp=0/0/0/0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (MUL_LAT + 4) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) rdy_cnt++;
      if (busy !== 1'b0) busy_bad++;
    end
    checks++;
    if (rdy_cnt != 0 || busy_bad != 0) begin
      failures++; $display("FAIL post_reset rdy=%0d busy_cycles=%0d exp=0/0", rdy_cnt, busy_bad);
    end
    run_op("mul_2x3_after_reset", 1'b1, 32'd2, 32'd3, 32'd6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_abort();
    test_both_ctrl();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
